// File: rtl/pipe_reg_fd_skid.sv
// Fetch-to-decode pipeline register with valid/ready handshake and a one-entry skid buffer.
// Holds NOP_INSTR when empty and keeps saturating stall/bubble counters.
module pipe_reg_fd_skid #(
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          PC_W      = 32,
  parameter logic [DATA_W-1:0]    NOP_INSTR = '0,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc4,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_instr;
  logic [PC_W-1:0]   r_m_pc4;
  logic              r_s_valid;
  logic [DATA_W-1:0] r_s_instr;
  logic [PC_W-1:0]   r_s_pc4;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_m_load;
  logic w_s_capture;

  // Ready depends only on skid occupancy, so there is no combinational path from out_ready.
  assign w_in_fire   = in_valid & ~r_s_valid;
  assign w_out_fire  = r_m_valid & out_ready;
  assign w_m_load    = ~r_m_valid | w_out_fire;
  assign w_s_capture = w_in_fire & r_m_valid & ~out_ready;

  always_ff @(posedge CLK) begin
    if (reset || flush) begin
      r_m_valid <= 1'b0;
      r_m_instr <= NOP_INSTR;
      r_m_pc4   <= '0;
    end else if (w_m_load) begin
      if (r_s_valid) begin
        r_m_valid <= 1'b1;
        r_m_instr <= r_s_instr;
        r_m_pc4   <= r_s_pc4;
      end else if (w_in_fire) begin
        r_m_valid <= 1'b1;
        r_m_instr <= in_instr;
        r_m_pc4   <= in_pc4;
      end else begin
        r_m_valid <= 1'b0;
        r_m_instr <= NOP_INSTR;
      end
    end
  end

  // Skid catches the one beat accepted in the first stalled cycle.
  always_ff @(posedge CLK) begin
    if (reset || flush) begin
      r_s_valid <= 1'b0;
      r_s_instr <= NOP_INSTR;
      r_s_pc4   <= '0;
    end else if (w_s_capture) begin
      r_s_valid <= 1'b1;
      r_s_instr <= in_instr;
      r_s_pc4   <= in_pc4;
    end else if (r_s_valid && w_m_load) begin
      r_s_valid <= 1'b0;
    end
  end

  // Saturating performance counters; flush leaves them untouched.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (r_m_valid && !out_ready && r_stall_cnt != CNT_MAX)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (!r_m_valid && out_ready && r_bubble_cnt != CNT_MAX)
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign in_ready   = ~r_s_valid;
  assign out_valid  = r_m_valid;
  assign out_instr  = r_m_instr;
  assign out_pc4    = r_m_pc4;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_reg_fd_skid.sv
// Self-checking bench for pipe_reg_fd_skid: occupancy model plus a scoreboard queue of accepted beats.
module tb_pipe_reg_fd_skid;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned CNT_W  = 16;
  localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [PC_W-1:0]   pc4;
  } beat_t;

  logic              CLK = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_instr, out_instr;
  logic [PC_W-1:0]   in_pc4, out_pc4;
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

  pipe_reg_fd_skid #(
    .DATA_W(DATA_W), .PC_W(PC_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc4(in_pc4),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc4(out_pc4),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 CLK = ~CLK;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  int                occ = 0;
  beat_t             sb_q[$];
  logic [CNT_W-1:0]  e_stall  = '0;
  logic [CNT_W-1:0]  e_bubble = '0;
  logic [DATA_W-1:0] nxt_instr = 32'h1000_0001;
  logic [PC_W-1:0]   nxt_pc    = 32'h4;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("in_ready", 64'(in_ready), 64'(occ < 2));
    chk("out_valid", 64'(out_valid), 64'(occ >= 1));
    if (occ >= 1 && sb_q.size() > 0) begin
      chk("hold_instr", 64'(out_instr), 64'(sb_q[0].instr));
      chk("hold_pc4", 64'(out_pc4), 64'(sb_q[0].pc4));
    end else begin
      chk("idle_nop", 64'(out_instr), 64'(NOP));
    end
    chk("stall_cnt", 64'(stall_cnt), 64'(e_stall));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(e_bubble));
  endtask

  // One clock: drive, compare a consumed beat, advance the model at the edge, then check.
  task automatic tick(input logic v, input logic r, input logic fl, input logic rs);
    logic fin, fout;
    in_valid  = v;
    out_ready = r;
    flush     = fl;
    reset     = rs;
    in_instr  = nxt_instr;
    in_pc4    = nxt_pc;
    fin  = v && (occ < 2);
    fout = (occ >= 1) && r;
    if (!rs && fout) begin
      if (sb_q.size() == 0) chk("sb_underflow", 64'(sb_q.size()), 64'd1);
      else begin
        chk("pop_instr", 64'(out_instr), 64'(sb_q[0].instr));
        chk("pop_pc4", 64'(out_pc4), 64'(sb_q[0].pc4));
      end
    end
    @(posedge CLK);
    if (rs) begin
      occ = 0;
      sb_q.delete();
      e_stall  = '0;
      e_bubble = '0;
    end else begin
      if (occ >= 1 && !r && e_stall != '1) e_stall++;
      if (occ == 0 && r && e_bubble != '1) e_bubble++;
      if (fl) begin
        occ = 0;
        sb_q.delete();
      end else begin
        if (fout) begin
          void'(sb_q.pop_front());
          occ--;
        end
        if (fin) begin
          sb_q.push_back('{instr: nxt_instr, pc4: nxt_pc});
          occ++;
        end
      end
    end
    if (fin && !rs && !fl) begin
      nxt_instr = nxt_instr + 32'd1;
      nxt_pc    = nxt_pc + 32'd4;
    end
    #1;
    check_state();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ovalid"}, 64'(out_valid), 64'd0);
    chk({tag, "_iready"}, 64'(in_ready), 64'd1);
    chk({tag, "_instr"}, 64'(out_instr), 64'(NOP));
    chk({tag, "_pc4"}, 64'(out_pc4), 64'd0);
    chk({tag, "_stall"}, 64'(stall_cnt), 64'd0);
    chk({tag, "_bubble"}, 64'(bubble_cnt), 64'd0);
  endtask

  initial begin
    in_valid = 0; out_ready = 0; flush = 0; reset = 1; in_instr = '0; in_pc4 = '0;

    // Streaming at full rate
    tick(0, 1, 0, 1);
    check_reset_vals("rst");
    nxt_instr = 32'h1000_0001; nxt_pc = 32'h4;
    for (int i = 0; i < 8; i++) tick(1, 1, 0, 0);
    tick(0, 1, 0, 0);
    chk("stream_stall", 64'(stall_cnt), 64'd0);
    chk("stream_bubble", 64'(bubble_cnt), 64'd1);
    chk("stream_last", 64'(nxt_instr), 64'h1000_0009);

    // Three-cycle stall in the middle of a stream
    tick(0, 1, 0, 1);
    for (int i = 0; i < 10; i++) tick(1, !(i inside {3, 4, 5}), 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
    chk("stall3", 64'(stall_cnt), 64'd3);

    // Flush with both entries full and a beat on the input
    tick(0, 1, 0, 1);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("full_iready", 64'(in_ready), 64'd0);
    tick(1, 0, 1, 0);
    chk("fl_ovalid", 64'(out_valid), 64'd0);
    chk("fl_instr", 64'(out_instr), 64'(NOP));
    chk("fl_pc4", 64'(out_pc4), 64'd0);
    chk("fl_iready", 64'(in_ready), 64'd1);
    tick(1, 1, 0, 0);
    chk("post_fl_valid", 64'(out_valid), 64'd1);
    tick(0, 1, 0, 0);

    // Reset while stalled with both entries full
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("pre_rst_stall_nz", 64'(stall_cnt != '0), 64'd1);
    tick(1, 0, 0, 1);
    check_reset_vals("midrst");

    // Bubble counter saturation
    for (int i = 0; i < 65600; i++) tick(0, 1, 0, 0);
    chk("bubble_sat", 64'(bubble_cnt), 64'hffff);

    // Random traffic with occasional flushes
    tick(0, 1, 0, 1);
    for (int i = 0; i < 5000; i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
    chk("drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
